// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the two-requester SPI monarch arbiter.
// Holds the arbiter state encoding, the grant index type and the round-robin pick rule.
package spi_arb_pkg;

  localparam int CMD_W = 16;

  typedef logic [CMD_W-1:0] cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    GAP
  } state_t;

  // Requester index: 0 = inertial sensor, 1 = A2D.
  typedef logic gnt_t;

  // With both pending, the requester that did not win last time goes next.
  function automatic gnt_t pick_grant(input logic [1:0] pend, input gnt_t last);
    if (pend == 2'b11) return gnt_t'(~last);
    return gnt_t'(pend[1]);
  endfunction

endpackage

// File: rtl/spi_arb_if.sv
// Requester and monarch signal bundle for spi_arb.
// slave is the arbiter's view; master is the view of whatever drives the requesters and monarch.
interface spi_arb_if;
  import spi_arb_pkg::*;

  logic       req0_snd;
  cmd_t       req0_cmd;
  logic       req0_done;
  logic       req1_snd;
  cmd_t       req1_cmd;
  logic       req1_done;
  cmd_t       resp;
  logic [1:0] ovf;
  logic       mon_snd;
  cmd_t       mon_cmd;
  logic       mon_done;
  cmd_t       mon_resp;
  logic       err;

  modport slave (
    input  req0_snd, req0_cmd, req1_snd, req1_cmd, mon_done, mon_resp,
    output req0_done, req1_done, resp, ovf, mon_snd, mon_cmd, err
  );

  modport master (
    output req0_snd, req0_cmd, req1_snd, req1_cmd, mon_done, mon_resp,
    input  req0_done, req1_done, resp, ovf, mon_snd, mon_cmd, err
  );

endinterface

// File: rtl/spi_arb_port.sv
// Per-requester pending latch: holds one command until the arbiter clears it.
// A send arriving while already pending is dropped and flagged in a sticky ovf bit.
module spi_arb_port
  import spi_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic snd,
  input  cmd_t cmd,
  input  logic clr,
  output logic pend,
  output cmd_t cmd_q,
  output logic ovf
);

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend  <= 1'b0;
      cmd_q <= '0;
      ovf   <= 1'b0;
    end else begin
      // A new send in the same cycle as the clear wins and refills the slot.
      if (snd && (!pend || clr)) begin
        pend  <= 1'b1;
        cmd_q <= cmd;
      end else if (clr) begin
        pend <= 1'b0;
      end
      if (snd && pend && !clr) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/spi_arb.sv
// Round-robin arbiter sharing one SPI monarch between two requesters, with a guard gap.
// Define SPI_ARB_TIMEOUT_EN to add a WAIT-state watchdog that aborts a stuck transaction.
module spi_arb
  import spi_arb_pkg::*;
#(
  parameter int unsigned GAP_CYC = 4,
  parameter int unsigned TMO_CYC = 50000
) (
  input logic     clk,
  input logic     rst,
  spi_arb_if.slave bus
);

  if (GAP_CYC == 0 || GAP_CYC > 255 || TMO_CYC == 0 || TMO_CYC > 65535) begin : g_param_chk
    $error("spi_arb: GAP_CYC or TMO_CYC out of range");
  end

  localparam logic [7:0] GAP_LD = 8'(GAP_CYC);

  logic [1:0] pend;
  logic [1:0] ovf;
  cmd_t       port_cmd [2];
  gnt_t       pick;

  state_t     state;
  gnt_t       last_grant;
  logic [1:0] clr_q;
  logic [1:0] done_q;
  logic       mon_snd_q;
  cmd_t       mon_cmd_q;
  cmd_t       resp_q;
  logic [7:0] gap_cnt;

  spi_arb_port u_port0 (
    .clk   (clk),
    .rst   (rst),
    .snd   (bus.req0_snd),
    .cmd   (bus.req0_cmd),
    .clr   (clr_q[0]),
    .pend  (pend[0]),
    .cmd_q (port_cmd[0]),
    .ovf   (ovf[0])
  );

  spi_arb_port u_port1 (
    .clk   (clk),
    .rst   (rst),
    .snd   (bus.req1_snd),
    .cmd   (bus.req1_cmd),
    .clr   (clr_q[1]),
    .pend  (pend[1]),
    .cmd_q (port_cmd[1]),
    .ovf   (ovf[1])
  );

  assign pick = pick_grant(pend, last_grant);

`ifdef SPI_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);
  logic [15:0] wd_cnt;
  logic        err_q;
`endif

  // last_grant doubles as the owner of the transaction in flight while in WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      clr_q      <= 2'b00;
      done_q     <= 2'b00;
      mon_snd_q  <= 1'b0;
      mon_cmd_q  <= '0;
      resp_q     <= '0;
      gap_cnt    <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      wd_cnt     <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      mon_snd_q <= 1'b0;
      done_q    <= 2'b00;
      clr_q     <= 2'b00;
`ifdef SPI_ARB_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (|pend) begin
            mon_cmd_q  <= port_cmd[pick];
            mon_snd_q  <= 1'b1;
            last_grant <= pick;
            state      <= WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
            wd_cnt     <= '0;
`endif
          end
        end
        WAIT: begin
          if (bus.mon_done) begin
            resp_q             <= bus.mon_resp;
            done_q[last_grant] <= 1'b1;
            clr_q[last_grant]  <= 1'b1;
            gap_cnt            <= GAP_LD;
            state              <= GAP;
          end
`ifdef SPI_ARB_TIMEOUT_EN
          else if (wd_cnt == TMO_LAST) begin
            // Abandon the transaction: owner loses its request, no done pulse.
            err_q             <= 1'b1;
            clr_q[last_grant] <= 1'b1;
            gap_cnt           <= GAP_LD;
            state             <= GAP;
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
`endif
        end
        GAP: begin
          gap_cnt <= gap_cnt - 8'd1;
          if (gap_cnt == 8'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mon_snd   = mon_snd_q;
  assign bus.mon_cmd   = mon_cmd_q;
  assign bus.resp      = resp_q;
  assign bus.req0_done = done_q[0];
  assign bus.req1_done = done_q[1];
  assign bus.ovf       = ovf;
`ifdef SPI_ARB_TIMEOUT_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_spi_arb.sv
// Self-checking bench for spi_arb: directed scenarios followed by random traffic,
// all checked cycle by cycle against a transaction-level model of the arbitration rules.
module tb_spi_arb;
  import spi_arb_pkg::*;

  localparam int GAP = 4;
  localparam int TMO = 100;

  logic clk = 1'b0;
  logic rst;

  spi_arb_if bus ();

  spi_arb #(.GAP_CYC(GAP), .TMO_CYC(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model state: what the arbiter should be holding after each edge.
  int          cyc;
  logic [1:0]  m_pend;
  logic [15:0] m_cmd [2];
  logic [1:0]  m_ovf;
  int          m_last;
  bit          busy;
  int          last_end;
  logic [15:0] m_resp;
  logic [1:0]  snap;
  int          snd_at;

  // Monarch responder and scenario knobs.
  int          done_cyc;
  logic [15:0] done_resp;
  int          exp_done;
  int          fix_delay;
  bit          use_fix;
  logic [15:0] fix_resp;
  bit          hang;
  bit          auto_rereq;
  bit          spur_en;
  bit          spur_once;

  int snd_log[$];
  int grant_log[$];
  int done_log[$];
  int err_log[$];

  task automatic do_reset();
    rst = 1'b1;
    bus.req0_snd = 1'b0; bus.req0_cmd = '0;
    bus.req1_snd = 1'b0; bus.req1_cmd = '0;
    bus.mon_done = 1'b0; bus.mon_resp = '0;
    @(posedge clk); #1;
    check("rst_mon_snd", bus.mon_snd, 0);
    check("rst_mon_cmd", bus.mon_cmd, 0);
    check("rst_resp", bus.resp, 0);
    check("rst_req0_done", bus.req0_done, 0);
    check("rst_req1_done", bus.req1_done, 0);
    check("rst_ovf", bus.ovf, 0);
    check("rst_err", bus.err, 0);
    rst = 1'b0;
    cyc = 0; m_pend = 2'b00; m_cmd = '{default: '0}; m_ovf = 2'b00; m_last = 1;
    busy = 0; last_end = -1000; m_resp = '0; snap = 2'b00; snd_at = -1;
    done_cyc = -1; exp_done = -1; fix_delay = -1; use_fix = 0; fix_resp = '0;
    hang = 0; auto_rereq = 0; spur_en = 0; spur_once = 0;
    snd_log.delete(); grant_log.delete(); done_log.delete(); err_log.delete();
  endtask

  // One clock: check this cycle's outputs against the model, then drive the inputs.
  task automatic step(input bit s0, input logic [15:0] c0, input bit s1, input logic [15:0] c1);
    bit          clr [2];
    bit          sn [2];
    logic [15:0] cn [2];
    bit          exp_snd;
    bit          e_err;
    int          g;
    @(posedge clk); #1;
    cyc++;
    clr = '{default: 1'b0};
    sn  = '{s0, s1};
    cn  = '{c0, c1};

    // A grant is due when the arbiter was idle last cycle with something pending.
    exp_snd = !busy && (cyc - 1 >= last_end + GAP) && (snap != 2'b00);
    check("mon_snd", bus.mon_snd, exp_snd);
    if (bus.mon_snd && exp_snd) begin
      g = (snap == 2'b11) ? 1 - m_last : (snap[1] ? 1 : 0);
      check("mon_cmd", bus.mon_cmd, m_cmd[g]);
      m_last = g; busy = 1; snd_at = cyc;
      snd_log.push_back(cyc); grant_log.push_back(g);
      if (hang) done_cyc = -1;
      else begin
        done_cyc  = cyc + ((fix_delay >= 0) ? fix_delay : int'($urandom_range(0, 5)));
        done_resp = use_fix ? fix_resp : 16'($urandom);
      end
    end

    check("req0_done", bus.req0_done, (cyc == exp_done) && (m_last == 0));
    check("req1_done", bus.req1_done, (cyc == exp_done) && (m_last == 1));
    if (cyc == exp_done) begin
      m_resp = done_resp; busy = 0; last_end = cyc; clr[m_last] = 1'b1;
      done_log.push_back(cyc);
      if (auto_rereq) begin sn[m_last] = 1'b1; cn[m_last] = 16'($urandom); end
    end

    e_err = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
    if (busy && done_cyc < 0 && cyc == snd_at + TMO) begin
      e_err = 1'b1; busy = 0; last_end = cyc; clr[m_last] = 1'b1;
      err_log.push_back(cyc);
    end
`endif
    check("err", bus.err, e_err);
    check("resp", bus.resp, m_resp);
    check("ovf", bus.ovf, m_ovf);

    snap = m_pend;
    for (int i = 0; i < 2; i++) begin
      if (sn[i] && (!m_pend[i] || clr[i])) begin
        m_pend[i] = 1'b1; m_cmd[i] = cn[i];
      end else if (clr[i]) m_pend[i] = 1'b0;
      else if (sn[i]) m_ovf[i] = 1'b1;
    end

    bus.req0_snd = sn[0]; bus.req0_cmd = cn[0];
    bus.req1_snd = sn[1]; bus.req1_cmd = cn[1];
    bus.mon_done = 1'b0;  bus.mon_resp = 16'($urandom);
    if (busy && cyc == done_cyc) begin
      bus.mon_done = 1'b1; bus.mon_resp = done_resp; exp_done = cyc + 1;
    end else if (!busy && (spur_once || (spur_en && $urandom_range(0, 7) == 0))) begin
      bus.mon_done = 1'b1; spur_once = 0;
    end
  endtask

  task automatic wait_done(input int n, input int budget);
    int k = 0;
    while (done_log.size() < n && k < budget) begin
      step(0, '0, 0, '0);
      k++;
    end
    check("wait_budget", done_log.size() >= n, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    // Single request: latency and response routing.
    do_reset();
    repeat (4) step(0, '0, 0, '0);
    fix_delay = 13; use_fix = 1; fix_resp = 16'h1234;
    step(1, 16'hA5A5, 0, '0);
    wait_done(1, 40);
    check("t1_snd_cyc", snd_log[0], 7);
    check("t1_cmd", bus.mon_cmd, 16'hA5A5);
    check("t1_done_cyc", done_log[0], 21);
    check("t1_resp", bus.resp, 16'h1234);

    // Tie after reset: requester 0 first, then 1 after the guard gap.
    do_reset();
    step(1, 16'h0001, 1, 16'h0002);
    wait_done(2, 60);
    check("t2_first", grant_log[0], 0);
    check("t2_second", grant_log[1], 1);
    check("t2_gap", snd_log[1] - done_log[0], GAP + 1);

    // Both re-request on every done: strict alternation, no overflow.
    do_reset();
    auto_rereq = 1;
    step(1, 16'h0010, 1, 16'h0020);
    wait_done(8, 200);
    auto_rereq = 0;
    for (int i = 0; i < 8; i++) check("t3_order", grant_log[i], i % 2);
    check("t3_ovf", bus.ovf, 2'b00);

    // Overflow: second send while pending is dropped and flagged.
    do_reset();
    step(0, '0, 1, 16'h0003);
    step(0, '0, 1, 16'h0004);
    step(0, '0, 0, '0);
    check("t4_ovf", bus.ovf, 2'b10);
    check("t4_cmd", bus.mon_cmd, 16'h0003);
    wait_done(1, 30);
    repeat (10) step(0, '0, 0, '0);
    check("t4_ovf_sticky", bus.ovf, 2'b10);

`ifdef SPI_ARB_TIMEOUT_EN
    // Monarch never answers: abort, then the other requester is served.
    do_reset();
    hang = 1;
    step(1, 16'h00A0, 0, '0);
    step(0, '0, 1, 16'h00B0);
    repeat (105) step(0, '0, 0, '0);
    hang = 0;
    wait_done(1, 40);
    check("t5_err_cyc", err_log[0], snd_log[0] + TMO);
    check("t5_regrant", grant_log[1], 1);
`endif

    // Reset in WAIT abandons the transaction; a late mon_done is ignored.
    do_reset();
    hang = 1;
    step(1, 16'h0C0C, 0, '0);
    repeat (4) step(0, '0, 0, '0);
    do_reset();
    spur_once = 1;
    step(0, '0, 0, '0);
    step(0, '0, 0, '0);
    check("t6_late_resp", bus.resp, 16'h0000);
    step(1, 16'hCAFE, 0, '0);
    wait_done(1, 30);
    check("t6_restart", snd_log[0], 5);

    // Random traffic with random monarch latency and stray mon_done pulses.
    do_reset();
    spur_en = 1;
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 3) == 0, 16'($urandom), $urandom_range(0, 3) == 0, 16'($urandom));
    spur_en = 0;
    repeat (20) step(0, '0, 0, '0);
    check("t7_activity", done_log.size() > 20, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
